// File: rtl/cmd_read.sv
// SD CMD-line response receiver.
// Armed by start_rx_i after a command has gone out. It waits for the response start bit and
// captures a 48-bit or 136-bit frame. While doing so it checks the CRC7, the index field, the
// framing bits and the NCR timeout, then reports all of it with a single done pulse.
//
// Handshake: start_rx_i is a one-cycle request that is accepted only while rx_busy_o is low;
// there is no back-pressure. rsp_valid_o is a one-cycle strobe (no ready) that covers every
// outcome. rsp_o, rsp_idx_o and the flags are valid on that strobe and hold until the next
// accepted start_rx_i.
module cmd_read #(
   parameter int TimeoutCycles = 64,
   parameter int TimeoutWidth  = 7
) (
   input  logic         sd_freq_clk_i,
   input  logic         rst_i,
   input  logic         start_rx_i,
   input  logic         long_rsp_i,
   input  logic         check_crc_i,
   input  logic         check_idx_i,
   input  logic [5:0]   exp_idx_i,
   input  logic         sd_cmd_i,
   output logic         rx_busy_o,
   output logic         rsp_valid_o,
   output logic [119:0] rsp_o,
   output logic [5:0]   rsp_idx_o,
   output logic         crc_err_o,
   output logic         idx_err_o,
   output logic         frame_err_o,
   output logic         timeout_o,
   output logic [2:0]   state_o
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_START = 3'd1,
      RECV       = 3'd2,
      CRC        = 3'd3,
      END_BIT    = 3'd4,
      DONE       = 3'd5
   } state_t;

   // bit_cnt counts frame bits after the start bit. These are the counts of the last payload
   // bit and of the last CRC bit.
   localparam logic [7:0] SHORT_PAYLOAD_LAST = 8'd39;
   localparam logic [7:0] LONG_PAYLOAD_LAST  = 8'd127;
   localparam logic [7:0] SHORT_CRC_LAST     = 8'd46;
   localparam logic [7:0] LONG_CRC_LAST      = 8'd134;
   localparam logic [TimeoutWidth-1:0] TIMEOUT_LAST = TimeoutWidth'(TimeoutCycles - 1);

   state_t state;
   state_t state_next;

   logic                    long_q;
   logic                    check_crc_q;
   logic                    check_idx_q;
   logic [5:0]              exp_idx_q;
   logic [7:0]              bit_cnt;
   logic [TimeoutWidth-1:0] timer;
   logic [6:0]              crc;
   logic [7:0]              payload_last;
   logic [7:0]              crc_last;

   // Serial CRC7, G = x^7 + x^3 + 1, processed MSB first.
   function automatic logic [6:0] crc7_next(input logic [6:0] cur, input logic din);
      logic fb;
      fb = din ^ cur[6];
      return {cur[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   assign payload_last = long_q ? LONG_PAYLOAD_LAST : SHORT_PAYLOAD_LAST;
   assign crc_last     = long_q ? LONG_CRC_LAST : SHORT_CRC_LAST;

   assign rx_busy_o   = (state != IDLE);
   assign rsp_valid_o = (state == DONE);
   assign state_o     = state;

   // State register.
   always_ff @(posedge sd_freq_clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (start_rx_i) state_next = WAIT_START;
         WAIT_START: begin
            if (!sd_cmd_i)                  state_next = RECV;
            else if (timer == TIMEOUT_LAST) state_next = DONE;
         end
         RECV:       if (bit_cnt == payload_last) state_next = CRC;
         CRC:        if (bit_cnt == crc_last) state_next = END_BIT;
         END_BIT:    state_next = DONE;
         DONE:       state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   // Datapath: mode latch, bit counter, timeout counter, CRC, capture shifters, flags.
   always_ff @(posedge sd_freq_clk_i) begin
      if (rst_i) begin
         long_q      <= 1'b0;
         check_crc_q <= 1'b0;
         check_idx_q <= 1'b0;
         exp_idx_q   <= 6'd0;
         bit_cnt     <= 8'd0;
         timer       <= '0;
         crc         <= 7'd0;
         rsp_o       <= 120'd0;
         rsp_idx_o   <= 6'd0;
         crc_err_o   <= 1'b0;
         idx_err_o   <= 1'b0;
         frame_err_o <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_rx_i) begin
                  long_q      <= long_rsp_i;
                  check_crc_q <= check_crc_i;
                  check_idx_q <= check_idx_i;
                  exp_idx_q   <= exp_idx_i;
                  bit_cnt     <= 8'd0;
                  timer       <= '0;
                  crc         <= 7'd0;
                  rsp_o       <= 120'd0;
                  rsp_idx_o   <= 6'd0;
                  crc_err_o   <= 1'b0;
                  idx_err_o   <= 1'b0;
                  frame_err_o <= 1'b0;
                  timeout_o   <= 1'b0;
               end
            end
            WAIT_START: begin
               if (!sd_cmd_i) begin
                  bit_cnt <= 8'd1;
                  // The start bit is part of the short-frame CRC only; R2 covers the CID alone.
                  if (!long_q) crc <= crc7_next(crc, sd_cmd_i);
               end else if (timer == TIMEOUT_LAST) begin
                  timeout_o <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RECV: begin
               bit_cnt <= bit_cnt + 8'd1;
               if (bit_cnt == 8'd1 && sd_cmd_i) frame_err_o <= 1'b1;
               // Counts 2..7 hold the index (short) or the reserved field (long).
               if (bit_cnt >= 8'd2 && bit_cnt <= 8'd7) rsp_idx_o <= {rsp_idx_o[4:0], sd_cmd_i};
               // Everything from count 8 on is content: 32 bits short, 120 bits long.
               if (bit_cnt >= 8'd8) rsp_o <= {rsp_o[118:0], sd_cmd_i};
               if (!long_q || bit_cnt >= 8'd8) crc <= crc7_next(crc, sd_cmd_i);
            end
            CRC: begin
               bit_cnt <= bit_cnt + 8'd1;
               if (check_crc_q && (sd_cmd_i != crc[6])) crc_err_o <= 1'b1;
               crc <= {crc[5:0], 1'b0};
            end
            END_BIT: begin
               if (!sd_cmd_i) frame_err_o <= 1'b1;
               if (check_idx_q && !long_q && (rsp_idx_o != exp_idx_q)) idx_err_o <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
